// File: rtl/jogo_desafio_memoria_core_if.sv
// Player-facing signals of the memory game core: start, configuration and buttons in;
// game LEDs, status colour and end-of-game flags out.
interface jogo_desafio_memoria_core_if;
    logic       jogar;
    logic [1:0] configuracao;
    logic [3:0] botoes;
    logic [2:0] leds_rgb;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic       pronto;
    logic [3:0] leds;

    modport master (
        output jogar, configuracao, botoes,
        input  leds_rgb, ganhou, perdeu, timeout, pronto, leds
    );

    modport slave (
        input  jogar, configuracao, botoes,
        output leds_rgb, ganhou, perdeu, timeout, pronto, leds
    );
endinterface

// File: rtl/jogo_desafio_memoria_core.sv
// "Simon" memory game core: shows a growing LED sequence from a 16x4 RAM and checks the presses.
// Optional per-press timeout is enabled by defining JOGO_TIMEOUT_EN.
module jogo_desafio_memoria_core #(
    parameter int unsigned LED_ON_CYCLES  = 1000,
    parameter int unsigned LED_OFF_CYCLES = 500,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                              clock,
    input  logic                              reset,
    jogo_desafio_memoria_core_if.slave        jogo,
    output logic                              db_igual,
    output logic [6:0]                        db_contagem,
    output logic [6:0]                        db_memoria,
    output logic [6:0]                        db_estado,
    output logic [6:0]                        db_jogadafeita,
    output logic [6:0]                        db_limite_rodada,
    output logic                              db_clock,
    output logic                              db_iniciar,
    output logic                              db_enderecoIgualLimite,
    output logic                              db_timeout,
    output logic                              db_modo,
    output logic                              db_configuracao,
    output logic                              db_escrita
);

    typedef enum logic [4:0] {
        INICIAL             = 5'b00000,
        PREPARACAO          = 5'b00001,
        CARREGA_LED         = 5'b00010,
        MOSTRA_LED          = 5'b00011,
        MOSTRA_APAGADO      = 5'b00101,
        PROXIMO_LED         = 5'b00110,
        ESPERA              = 5'b00111,
        REGISTRA            = 5'b01000,
        COMPARA             = 5'b01001,
        PROXIMA_JOGADA      = 5'b01010,
        FIM_RODADA          = 5'b01011,
        FIM_ERROU           = 5'b01100,
        PROXIMA_RODADA      = 5'b01101,
        ESPERA_ESCRITA      = 5'b01110,
        FIM_TIMEOUT         = 5'b01111,
        FIM_SEQUENCIA_TIMER = 5'b10000,
        ESCREVE             = 5'b10001,
        FIM_ACERTOU         = 5'b10010
    } estado_t;

    // One counter times both the LED phases and the press timeout, sized for the longest.
    localparam int unsigned MAX_LED = (LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_LED > TIMEOUT_CYCLES) ? MAX_LED : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] FIM_ON  = CNT_W'(LED_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIM_OFF = CNT_W'(LED_OFF_CYCLES - 1);
`ifdef JOGO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] FIM_TEMPO = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    estado_t          estado, proximo;
    logic [3:0]       endereco, limite, jogada, botoes_q, dados;
    logic             pressionado_q, modo, escrita;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ram [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                   4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    logic jogada_feita, igual, endereco_igual_limite, ultima_rodada;
    logic zera_endereco, inc_endereco, zera_limite, inc_limite, carrega_cfg;
    logic grava_jogada, escreve_ram, temporizado, tempo_esgotado;
    logic [3:0] leds;
    logic [2:0] leds_rgb;
    logic ganhou, perdeu, timeout, pronto;

    assign jogada_feita          = (|botoes_q) & ~pressionado_q;
    assign dados                 = ram[endereco];
    assign igual                 = (jogada == dados);
    assign endereco_igual_limite = (endereco == limite);
    assign ultima_rodada         = modo ? (limite == 4'd15) : (limite == 4'd3);

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        proximo        = estado;
        zera_endereco  = 1'b0;
        inc_endereco   = 1'b0;
        zera_limite    = 1'b0;
        inc_limite     = 1'b0;
        carrega_cfg    = 1'b0;
        grava_jogada   = 1'b0;
        escreve_ram    = 1'b0;
        temporizado    = 1'b0;
        tempo_esgotado = 1'b0;
        case (estado)
            INICIAL:             if (jogo.jogar) proximo = PREPARACAO;
            PREPARACAO: begin
                zera_endereco = 1'b1;
                zera_limite   = 1'b1;
                carrega_cfg   = 1'b1;
                proximo       = CARREGA_LED;
            end
            CARREGA_LED:         proximo = MOSTRA_LED;
            MOSTRA_LED: begin
                temporizado = 1'b1;
                if (cnt == FIM_ON) proximo = MOSTRA_APAGADO;
            end
            MOSTRA_APAGADO: begin
                temporizado = 1'b1;
                if (cnt == FIM_OFF) proximo = endereco_igual_limite ? FIM_SEQUENCIA_TIMER : PROXIMO_LED;
            end
            PROXIMO_LED: begin
                inc_endereco = 1'b1;
                proximo      = CARREGA_LED;
            end
            FIM_SEQUENCIA_TIMER: begin
                zera_endereco = 1'b1;
                proximo       = ESPERA;
            end
            ESPERA, ESPERA_ESCRITA: begin
`ifdef JOGO_TIMEOUT_EN
                temporizado = 1'b1;
`endif
                if (jogada_feita) begin
                    grava_jogada = 1'b1;
                    proximo      = (estado == ESPERA) ? REGISTRA : ESCREVE;
                end
`ifdef JOGO_TIMEOUT_EN
                else if (cnt == FIM_TEMPO) begin
                    tempo_esgotado = 1'b1;
                    proximo        = FIM_TIMEOUT;
                end
`endif
            end
            REGISTRA:            proximo = COMPARA;
            COMPARA: begin
                if (!igual)                     proximo = FIM_ERROU;
                else if (endereco_igual_limite) proximo = FIM_RODADA;
                else                            proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: begin
                inc_endereco = 1'b1;
                proximo      = ESPERA;
            end
            FIM_RODADA: begin
                if (ultima_rodada) proximo = FIM_ACERTOU;
                else if (escrita)  proximo = ESPERA_ESCRITA;
                else               proximo = PROXIMA_RODADA;
            end
            ESCREVE: begin
                escreve_ram = 1'b1;
                proximo     = PROXIMA_RODADA;
            end
            PROXIMA_RODADA: begin
                inc_limite    = 1'b1;
                zera_endereco = 1'b1;
                proximo       = CARREGA_LED;
            end
            FIM_ERROU, FIM_ACERTOU, FIM_TIMEOUT:
                if (jogo.jogar) proximo = PREPARACAO;
            default:             proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (reset) begin
            estado        <= INICIAL;
            endereco      <= '0;
            limite        <= '0;
            jogada        <= '0;
            botoes_q      <= '0;
            pressionado_q <= 1'b0;
            modo          <= 1'b0;
            escrita       <= 1'b0;
            cnt           <= '0;
        end else begin
            estado        <= proximo;
            botoes_q      <= jogo.botoes;
            pressionado_q <= |botoes_q;
            if (zera_endereco)     endereco <= '0;
            else if (inc_endereco) endereco <= endereco + 4'd1;
            if (zera_limite)       limite <= '0;
            else if (inc_limite)   limite <= limite + 4'd1;
            if (grava_jogada)      jogada <= botoes_q;
            if (carrega_cfg) begin
                modo    <= jogo.configuracao[0];
                escrita <= jogo.configuracao[1];
            end
            // The counter restarts on every state change, so each timed phase starts from zero.
            cnt <= (temporizado && proximo == estado) ? cnt + CNT_W'(1) : '0;
        end
    end

    // NOTE: the RAM is kept out of the reset branch on purpose; its contents survive reset.
    always_ff @(posedge clock) begin
        if (escreve_ram && !reset) ram[limite + 4'd1] <= jogada;
    end

    always_comb begin
        leds     = '0;
        leds_rgb = 3'b000;
        ganhou   = 1'b0;
        perdeu   = 1'b0;
        timeout  = 1'b0;
        pronto   = 1'b0;
        case (estado)
            CARREGA_LED, MOSTRA_APAGADO, PROXIMO_LED, FIM_SEQUENCIA_TIMER: leds_rgb = 3'b001;
            MOSTRA_LED: begin
                leds_rgb = 3'b001;
                leds     = dados;
            end
            ESPERA:      leds = jogo.botoes;
            FIM_ERROU: begin
                perdeu   = 1'b1;
                pronto   = 1'b1;
                leds_rgb = 3'b100;
            end
            FIM_ACERTOU: begin
                ganhou   = 1'b1;
                pronto   = 1'b1;
                leds_rgb = 3'b010;
            end
            FIM_TIMEOUT: begin
`ifdef JOGO_TIMEOUT_EN
                timeout  = 1'b1;
`endif
                pronto   = 1'b1;
                leds_rgb = 3'b100;
            end
            default: ;
        endcase
    end

    assign jogo.leds     = leds;
    assign jogo.leds_rgb = leds_rgb;
    assign jogo.ganhou   = ganhou;
    assign jogo.perdeu   = perdeu;
    assign jogo.timeout  = timeout;
    assign jogo.pronto   = pronto;

    assign db_igual               = igual;
    assign db_contagem            = hex7(endereco);
    assign db_memoria             = hex7(dados);
    assign db_estado              = estado[4] ? 7'b0111111 : hex7(estado[3:0]);
    assign db_jogadafeita         = hex7(jogada);
    assign db_limite_rodada       = hex7(limite);
    assign db_clock               = clock;
    assign db_iniciar             = jogo.jogar;
    assign db_enderecoIgualLimite = endereco_igual_limite;
    assign db_timeout             = tempo_esgotado;
    assign db_modo                = modo;
    assign db_configuracao        = escrita;
    assign db_escrita             = escreve_ram;

endmodule

// File: tb/tb_jogo_desafio_memoria_core.sv
// Scoreboard bench for jogo_desafio_memoria_core: a player model issues games and queues the
// expected LED sequence, RAM writes and end results; a negedge monitor pops and compares.
module tb_jogo_desafio_memoria_core;

    localparam int unsigned ON_C  = 6;
    localparam int unsigned OFF_C = 3;
    localparam int unsigned TMO_C = 40;
    localparam int          LIMITE_ESPERA = 4000;

    // {ganhou, perdeu, timeout, leds_rgb}
    localparam logic [5:0] RES_GANHOU  = 6'b100_010;
    localparam logic [5:0] RES_PERDEU  = 6'b010_100;
    localparam logic [5:0] RES_TIMEOUT = 6'b001_100;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    jogo_desafio_memoria_core_if jogo();

    logic       db_igual, db_clock, db_iniciar, db_enderecoIgualLimite, db_timeout;
    logic       db_modo, db_configuracao, db_escrita;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite_rodada;

    jogo_desafio_memoria_core #(
        .LED_ON_CYCLES (ON_C),
        .LED_OFF_CYCLES(OFF_C),
        .TIMEOUT_CYCLES(TMO_C)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .jogo                  (jogo.slave),
        .db_igual              (db_igual),
        .db_contagem           (db_contagem),
        .db_memoria            (db_memoria),
        .db_estado             (db_estado),
        .db_jogadafeita        (db_jogadafeita),
        .db_limite_rodada      (db_limite_rodada),
        .db_clock              (db_clock),
        .db_iniciar            (db_iniciar),
        .db_enderecoIgualLimite(db_enderecoIgualLimite),
        .db_timeout            (db_timeout),
        .db_modo               (db_modo),
        .db_configuracao       (db_configuracao),
        .db_escrita            (db_escrita)
    );

    // Standard active-low gfedcba hex glyphs and the RAM power-up image.
    logic [6:0] seg7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0] ram_m [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    int n_tests = 0;
    int n_fail  = 0;
    int tmo_pulsos = 0;

    logic [3:0] led_q [$];
    logic [5:0] res_q [$];
    logic [3:0] wr_q  [$];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [6:0] seg, input string nome);
        int n = 0;
        while (db_estado !== seg && n < LIMITE_ESPERA) begin
            @(negedge clock);
            n++;
        end
        if (n >= LIMITE_ESPERA) check({nome, "_sem_resposta"}, db_estado, seg);
    endtask

    task automatic press(input logic [3:0] v, input logic espelho);
        jogo.botoes = v;
        #1;
        if (espelho) check("leds_espelho", jogo.leds, v);
        tick(3);
        jogo.botoes = 4'b0000;
        tick(3);
    endtask

    task automatic start_game(input logic [1:0] cfg);
        jogo.configuracao = cfg;
        jogo.jogar = 1'b1;
        tick(1);
        jogo.jogar = 1'b0;
        tick(1);
        check("flags_limpos", {jogo.ganhou, jogo.perdeu, jogo.timeout, jogo.pronto}, 4'b0000);
        check("db_modo", db_modo, cfg[0]);
        check("db_configuracao", db_configuracao, cfg[1]);
    endtask

    task automatic finish_game(input logic [6:0] seg_fim);
        int n = 0;
        while (jogo.pronto !== 1'b1 && n < LIMITE_ESPERA) begin
            @(negedge clock);
            n++;
        end
        check("pronto", jogo.pronto, 1'b1);
        check("estado_fim", db_estado, seg_fim);
    endtask

    // err_round < 0 plays a perfect game; wrong = 0 picks a random wrong pattern.
    task automatic play_game(input logic [1:0] cfg, input int err_round, input int err_pos,
                             input logic [3:0] wrong, input logic [3:0] first_write);
        int rounds;
        logic [3:0] v;
        rounds = cfg[0] ? 16 : 4;
        led_q.push_back(ram_m[0]);
        start_game(cfg);
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i <= r; i++) begin
                wait_state(seg7[7], "espera");
                if (r == err_round && i == err_pos) begin
                    v = wrong;
                    if (v == 4'd0 || v == ram_m[i]) begin
                        do v = 4'($urandom_range(1, 15)); while (v == ram_m[i]);
                    end
                    res_q.push_back(RES_PERDEU);
                    press(v, 1'b1);
                    finish_game(seg7[12]);
                    return;
                end
                if (i == r) begin
                    if (r == rounds - 1) res_q.push_back(RES_GANHOU);
                    else if (!cfg[1]) for (int k = 0; k <= r + 1; k++) led_q.push_back(ram_m[k]);
                end
                press(ram_m[i], 1'b1);
            end
            if (r == rounds - 1) begin
                finish_game(SEG_TRACO);
            end else if (cfg[1]) begin
                wait_state(seg7[14], "espera_escrita");
                v = (r == 0 && first_write != 4'd0) ? first_write : 4'($urandom_range(1, 15));
                ram_m[r + 1] = v;
                wr_q.push_back(v);
                for (int k = 0; k <= r + 1; k++) led_q.push_back(ram_m[k]);
                press(v, 1'b0);
            end
        end
    endtask

    // Monitor: compares every displayed LED, every end result and every RAM write.
    initial begin
        logic prev_show, prev_pronto, prev_esc, show;
        prev_show = 1'b0; prev_pronto = 1'b0; prev_esc = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_show = 1'b0; prev_pronto = 1'b0; prev_esc = 1'b0;
            end else begin
                show = (jogo.leds != 4'd0) && (jogo.leds_rgb == 3'b001);
                if (show && !prev_show) begin
                    if (led_q.size() == 0) check("led_inesperado", jogo.leds, 4'd0);
                    else check("led_sequencia", jogo.leds, led_q.pop_front());
                end
                if (jogo.pronto && !prev_pronto) begin
                    if (res_q.size() == 0) check("resultado_inesperado", jogo.pronto, 1'b0);
                    else check("resultado", {jogo.ganhou, jogo.perdeu, jogo.timeout, jogo.leds_rgb},
                               res_q.pop_front());
                end
                if (db_escrita && !prev_esc) begin
                    if (wr_q.size() == 0) check("escrita_inesperada", db_escrita, 1'b0);
                    else check("escrita_valor", db_jogadafeita, seg7[wr_q.pop_front()]);
                end
                if (db_timeout) tmo_pulsos++;
                prev_show = show; prev_pronto = jogo.pronto; prev_esc = db_escrita;
            end
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not end, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int er, ep;
        logic [1:0] cfg;
        int n;
        reset = 1'b1;
        jogo.jogar = 1'b0;
        jogo.configuracao = 2'b00;
        jogo.botoes = 4'b0000;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_estado", db_estado, seg7[0]);
        check("reset_flags", {jogo.ganhou, jogo.perdeu, jogo.timeout, jogo.pronto}, 4'b0000);
        check("reset_leds", jogo.leds, 4'd0);
        check("reset_rgb", jogo.leds_rgb, 3'b000);
        check("reset_contagem", db_contagem, seg7[0]);

        // Wrong press on the first round, then a fresh game without reset.
        play_game(2'b00, 0, 0, 4'b1111, 4'd0);
        check("perdeu_mantido", jogo.perdeu, 1'b1);
        play_game(2'b00, -1, 0, 4'd0, 4'd0);
        // Write mode: 1000 stored at address 1, then shown in round 2.
        play_game(2'b10, -1, 0, 4'd0, 4'b1000);
        // Boundaries: miss at the very last press of modo 0, full 16-round win in modo 1.
        play_game(2'b00, 3, 3, 4'd0, 4'd0);
        play_game(2'b01, -1, 0, 4'd0, 4'd0);

        for (int g = 0; g < 5; g++) begin
            cfg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                er = $urandom_range(0, cfg[0] ? 15 : 3);
                ep = $urandom_range(0, er);
            end else begin
                er = -1;
                ep = 0;
            end
            play_game(cfg, er, ep, 4'd0, 4'd0);
        end

`ifdef JOGO_TIMEOUT_EN
        tmo_pulsos = 0;
        led_q.push_back(ram_m[0]);
        start_game(2'b00);
        wait_state(seg7[7], "espera_timeout");
        res_q.push_back(RES_TIMEOUT);
        finish_game(seg7[15]);
        check("db_timeout_pulsos", tmo_pulsos, 1);
`else
        check("timeout_ausente", tmo_pulsos, 0);
`endif

        // Reset in the middle of the sequence display.
        led_q.push_back(ram_m[0]);
        start_game(2'b11);
        n = 0;
        while (jogo.leds == 4'd0 && n < LIMITE_ESPERA) begin
            @(negedge clock);
            n++;
        end
        check("mostra_led_rgb", jogo.leds_rgb, 3'b001);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("reset_meio_estado", db_estado, seg7[0]);
        check("reset_meio_leds", {jogo.leds, jogo.leds_rgb}, 7'd0);
        check("reset_meio_flags", {jogo.ganhou, jogo.perdeu, jogo.timeout, jogo.pronto}, 4'b0000);
        check("reset_meio_cfg", {db_modo, db_configuracao, db_escrita}, 3'b000);
        reset = 1'b0;
        tick(3);
        check("inicial_espera_jogar", db_estado, seg7[0]);

        tick(10);
        check("fila_leds_vazia", led_q.size(), 0);
        check("fila_resultados_vazia", res_q.size(), 0);
        check("fila_escritas_vazia", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
